sw_conditioner: RTL

Conditions the four raw push-button inputs before they reach the clock controller: synchronises, debounces and edge-detects each switch, and emits clean single-cycle press pulses. Sits directly upstream of the controller inside the clock top level. The raw pad signals enter here, and `o_sw_pulse` drives the controller's `i_sw0..i_sw3`. Optionally generates auto-repeat pulses on a held button so that time and alarm setting can scroll quickly.

---
 rtl/sw_cond_pkg.sv | 26 ++
 rtl/sw_debounce.sv | 134 +++++++++++++
 rtl/sw_conditioner.sv | 37 +++
 3 files changed

// File: rtl/sw_cond_pkg.sv
// Shared types and constants for the push-button conditioner.
// Holds the debounce FSM state enum, default timings and counter sizing.
package sw_cond_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } sw_state_e;

  localparam int DEF_NUM_SW        = 4;
  localparam int DEF_DEB_CYCLES    = 500000;
  localparam int DEF_REPEAT_DELAY  = 25000000;
  localparam int DEF_REPEAT_PERIOD = 10000000;

  // One spare bit above the largest count so saturation never aliases.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// Single-channel switch conditioner: 2-flop sync, debounce FSM, press/release
// pulses. Ports: clk, rst (sync, high), i_sw raw pad, o_pulse, o_level,
// o_release. Auto-repeat on hold is built only with SW_AUTOREPEAT_EN defined.
module sw_debounce
  import sw_cond_pkg::*;
#(
  parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
  parameter int SW_ACTIVE_LOW = 1,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst,
  input  logic i_sw,
  output logic o_pulse,
  output logic o_level,
  output logic o_release
);

  localparam int CW = cnt_width(DEB_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);
  // Raw pad level that means "released".
  localparam logic RELEASED = (SW_ACTIVE_LOW != 0);

  logic [1:0]    sync_q;
  logic          pressed;
  sw_state_e     state_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_inc;
  logic          press_q;
  logic          rel_q;
  logic          accept;

  assign pressed = sync_q[1] ^ RELEASED;
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
  assign accept  = (state_q == PRESS_WAIT) && pressed
                   && (cnt_q == DEB_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= {2{RELEASED}};
      state_q <= IDLE;
      cnt_q   <= '0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], i_sw};
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (pressed) begin
            state_q <= PRESS_WAIT;
            cnt_q   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!pressed) begin
            state_q <= IDLE;
          end else if (cnt_q == DEB_LAST) begin
            state_q <= PRESSED;
            press_q <= 1'b1;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        PRESSED: begin
          if (!pressed) begin
            state_q <= RELEASE_WAIT;
            cnt_q   <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (pressed) begin
            state_q <= PRESSED;
          end else if (cnt_q == DEB_LAST) begin
            state_q <= IDLE;
            rel_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef SW_AUTOREPEAT_EN
  localparam logic [CW-1:0] RD_LAST = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RP_LAST = CW'(REPEAT_PERIOD - 1);

  logic [CW-1:0] hold_q;
  logic          first_q;
  logic          rep_q;
  logic [CW-1:0] hold_inc;

  assign hold_inc = (hold_q == CNT_MAX) ? hold_q : hold_q + 1'b1;

  // Hold counter only advances while the button stays in PRESSED, so a
  // RELEASE_WAIT excursion freezes it and a bounce back resumes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q  <= '0;
      first_q <= 1'b1;
      rep_q   <= 1'b0;
    end else begin
      rep_q <= 1'b0;
      if (accept) begin
        hold_q  <= '0;
        first_q <= 1'b1;
      end else if (state_q == PRESSED && pressed) begin
        if (hold_q == (first_q ? RD_LAST : RP_LAST)) begin
          rep_q   <= 1'b1;
          hold_q  <= '0;
          first_q <= 1'b0;
        end else begin
          hold_q <= hold_inc;
        end
      end
    end
  end

  assign o_pulse = press_q | rep_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
  assign o_pulse       = press_q;
`endif

  assign o_level   = (state_q == PRESSED) || (state_q == RELEASE_WAIT);
  assign o_release = rel_q;

endmodule

// File: rtl/sw_conditioner.sv
// Push-button conditioner: NUM_SW independent sw_debounce channels.
// Ports: clk, rst, i_sw pads, o_sw_pulse, o_sw_level, o_sw_release.
// Optional auto-repeat is enabled by defining SW_AUTOREPEAT_EN.
module sw_conditioner
  import sw_cond_pkg::*;
#(
  parameter int NUM_SW        = DEF_NUM_SW,
  parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
  parameter int SW_ACTIVE_LOW = 1,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_SW-1:0] i_sw,
  output logic [NUM_SW-1:0] o_sw_pulse,
  output logic [NUM_SW-1:0] o_sw_level,
  output logic [NUM_SW-1:0] o_sw_release
);

  for (genvar g = 0; g < NUM_SW; g++) begin : g_ch
    sw_debounce #(
      .DEB_CYCLES   (DEB_CYCLES),
      .SW_ACTIVE_LOW(SW_ACTIVE_LOW),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_deb (
      .clk      (clk),
      .rst      (rst),
      .i_sw     (i_sw[g]),
      .o_pulse  (o_sw_pulse[g]),
      .o_level  (o_sw_level[g]),
      .o_release(o_sw_release[g])
    );
  end

endmodule
